multi_warp_fetcher: RTL

Instruction fetch unit shared by NUM_WARPS warps of one compute core.
- Each warp runs its own fetch state machine and has its own instruction buffer.
- A round-robin arbiter issues requests one at a time on a single instruction-memory read port.
- Adds per-warp flush (branch redirect) with safe discard of an in-flight response, which a single-warp fetcher lacks.
- Sits between the warp scheduler / PC logic and the decoder.

---
 rtl/multi_warp_fetcher_pkg.sv | 32 +++
 rtl/multi_warp_fetcher_arbiter.sv | 59 +++++
 rtl/multi_warp_fetcher.sv | 134 +++++++++++++
 3 files changed

// File: rtl/multi_warp_fetcher_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : multi_warp_fetcher_pkg
//  Brief    : Shared types and constants for the multi-warp instruction
//             fetcher (state encoding, default bus widths).
//  Revision : 1.0 - initial release
// ============================================================================
package multi_warp_fetcher_pkg;

    // Default memory-port widths; the typedefs below track these values
    localparam int c_addr_width_default  = 12;
    localparam int c_instr_width_default = 32;

    typedef logic [c_addr_width_default-1:0]  instruction_memory_address_t;
    typedef logic [c_instr_width_default-1:0] instruction_t;

    // Per-warp fetch state, as seen on the fetcher_state output
    typedef enum logic [1:0] {
        FS_IDLE     = 2'd0,
        FS_WAITING  = 2'd1,
        FS_FETCHING = 2'd2,
        FS_FETCHED  = 2'd3
    } fetcher_state_t;

    // Raw state constants used by the per-warp state registers
    localparam logic [1:0] c_idle     = 2'd0;
    localparam logic [1:0] c_waiting  = 2'd1;
    localparam logic [1:0] c_fetching = 2'd2;
    localparam logic [1:0] c_fetched  = 2'd3;

endpackage
`default_nettype wire

// File: rtl/multi_warp_fetcher_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : round_robin_arbiter
//  Brief    : N-way round-robin arbiter. Picks the first requester at or
//             after an internal pointer (wrapping), pointer advances past
//             the winner whenever a grant is issued.
//  Revision : 1.0 - initial release
// ============================================================================
module round_robin_arbiter #(
    parameter int N = 4,
    localparam int c_idx_width = (N > 1) ? $clog2(N) : 1
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [N-1:0]           i_request,
    input  logic                   i_enable,
    output logic [N-1:0]           o_grant,
    output logic [c_idx_width-1:0] o_grant_index,
    output logic                   o_grant_valid
);

    logic [c_idx_width-1:0] r_ptr;
    logic [c_idx_width-1:0] w_sel;
    int                     w_idx;

    // Scan requesters starting at the pointer, modulo N, first hit wins
    always_comb begin
        o_grant_valid = 1'b0;
        o_grant_index = '0;
        o_grant       = '0;
        w_idx         = 0;
        w_sel         = '0;
        for (int k = 0; k < N; k++) begin
            w_idx = int'(r_ptr) + k;
            if (w_idx >= N) begin
                w_idx = w_idx - N;
            end
            w_sel = c_idx_width'(w_idx);
            if (i_enable && !o_grant_valid && i_request[w_sel]) begin
                o_grant_valid = 1'b1;
                o_grant_index = w_sel;
            end
        end
        if (o_grant_valid) begin
            o_grant[o_grant_index] = 1'b1;
        end
    end

    // Move the pointer one past the most recent winner
    always_ff @(posedge clk) begin
        if (rst) begin
            r_ptr <= '0;
        end else if (o_grant_valid) begin
            r_ptr <= (o_grant_index == c_idx_width'(N - 1)) ? '0 : o_grant_index + 1'b1;
        end
    end

endmodule
`default_nettype wire

// File: rtl/multi_warp_fetcher.sv
`default_nettype none
// ============================================================================
//  Module   : multi_warp_fetcher
//  Brief    : Instruction fetch unit shared by NUM_WARPS warps. Each warp has
//             its own fetch FSM and instruction buffer; a round-robin arbiter
//             serialises requests onto one memory read port. A flush returns
//             a warp to IDLE and drops its in-flight response.
//  Revision : 1.0 - initial release
// ============================================================================
module multi_warp_fetcher
    import multi_warp_fetcher_pkg::*;
#(
    parameter int NUM_WARPS   = 4,
    parameter int ADDR_WIDTH  = c_addr_width_default,
    parameter int INSTR_WIDTH = c_instr_width_default
) (
    input  logic                             clk,
    input  logic                             reset,
    input  logic [NUM_WARPS-1:0]             fetch_req,
    input  logic [NUM_WARPS*ADDR_WIDTH-1:0]  pc,
    input  logic [NUM_WARPS-1:0]             consume,
    input  logic [NUM_WARPS-1:0]             flush,
    input  logic                             instruction_mem_read_ready,
    input  logic [INSTR_WIDTH-1:0]           instruction_mem_read_data,
    output logic                             instruction_mem_read_valid,
    output logic [ADDR_WIDTH-1:0]            instruction_mem_read_address,
    output logic [NUM_WARPS*2-1:0]           fetcher_state,
    output logic [NUM_WARPS*INSTR_WIDTH-1:0] instruction
);

    localparam int c_warp_idx_width = (NUM_WARPS > 1) ? $clog2(NUM_WARPS) : 1;

    logic                        r_valid;
    logic [ADDR_WIDTH-1:0]       r_address;
    logic                        r_kill;
    logic [c_warp_idx_width-1:0] r_owner;

    logic [NUM_WARPS-1:0]        w_request;
    logic [NUM_WARPS-1:0]        w_grant;
    logic [c_warp_idx_width-1:0] w_grant_index;
    logic                        w_grant_valid;
    logic                        w_complete;
    logic [ADDR_WIDTH-1:0]       w_warp_addr [NUM_WARPS];

    // A live (not killed) response is being returned this cycle
    assign w_complete = r_valid && instruction_mem_read_ready && !r_kill;

    round_robin_arbiter #(
        .N (NUM_WARPS)
    ) u_arbiter (
        .clk           (clk),
        .rst           (reset),
        .i_request     (w_request),
        .i_enable      (!r_valid),
        .o_grant       (w_grant),
        .o_grant_index (w_grant_index),
        .o_grant_valid (w_grant_valid)
    );

    for (genvar w = 0; w < NUM_WARPS; w++) begin : g_warp
        logic [1:0]             r_state;
        logic [ADDR_WIDTH-1:0]  r_addr;
        logic [INSTR_WIDTH-1:0] r_instr;

        // A warp being flushed this cycle must not win the port
        assign w_request[w]   = (r_state == c_waiting) && !flush[w];
        assign w_warp_addr[w] = r_addr;

        // Per-warp fetch FSM: flush beats consume beats fetch_req
        always_ff @(posedge clk) begin
            if (reset) begin
                r_state <= c_idle;
                r_addr  <= '0;
                r_instr <= '0;
            end else if (flush[w]) begin
                r_state <= c_idle;
            end else begin
                case (r_state)
                    c_idle: begin
                        if (fetch_req[w]) begin
                            r_state <= c_waiting;
                            r_addr  <= pc[w*ADDR_WIDTH +: ADDR_WIDTH];
                        end
                    end
                    c_waiting: begin
                        if (w_grant[w]) begin
                            r_state <= c_fetching;
                        end
                    end
                    c_fetching: begin
                        if (w_complete && (r_owner == c_warp_idx_width'(w))) begin
                            r_state <= c_fetched;
                            r_instr <= instruction_mem_read_data;
                        end
                    end
                    default: begin
                        if (consume[w]) begin
                            r_state <= c_idle;
                        end
                    end
                endcase
            end
        end

        assign fetcher_state[w*2 +: 2]                = r_state;
        assign instruction[w*INSTR_WIDTH +: INSTR_WIDTH] = r_instr;
    end

    // Memory port: one outstanding request, held stable until ready
    always_ff @(posedge clk) begin
        if (reset) begin
            r_valid   <= 1'b0;
            r_address <= '0;
            r_kill    <= 1'b0;
            r_owner   <= '0;
        end else if (r_valid) begin
            if (instruction_mem_read_ready) begin
                r_valid <= 1'b0;
                r_kill  <= 1'b0;
            end else if (flush[r_owner]) begin
                r_kill <= 1'b1;
            end
        end else if (w_grant_valid) begin
            r_valid   <= 1'b1;
            r_address <= w_warp_addr[w_grant_index];
            r_owner   <= w_grant_index;
        end
    end

    assign instruction_mem_read_valid   = r_valid;
    assign instruction_mem_read_address = r_address;

endmodule
`default_nettype wire
